// File: rtl/pipe_valid_controller.sv
// rtl/pipe_valid_controller.sv - 4-stage pipeline occupancy, stall, flush and halt sequencer
// Optional perf counters are built when PIPE_PERF_COUNTERS_EN is defined.
module pipe_valid_controller #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             set_invalid_sig_to_fetch,
    input  logic             set_invalid_sig_to_rf_read,
    input  logic             dmem_waitrequest,
    input  logic             halt_req,
    output logic             valid_in_fetch_stage,
    output logic             valid_in_rf_read_stage,
    output logic             valid_in_execute_stage,
    output logic             valid_in_writeback_stage,
    output logic             pc_write_en,
    output logic             halted,
    output logic             mem_timeout_err,
    output logic [CNT_W-1:0] perf_retired,
    output logic [CNT_W-1:0] perf_flush,
    output logic [CNT_W-1:0] perf_stall
);

    typedef enum logic [2:0] {
        ST_START    = 3'd0,
        ST_RUN      = 3'd1,
        ST_MEM_WAIT = 3'd2,
        ST_DRAIN    = 3'd3,
        ST_HALTED   = 3'd4
    } state_t;

    localparam int TCNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(MEM_TIMEOUT - 1);

    state_t            state, state_next;
    logic              occ_f, occ_r, occ_e, occ_w;
    logic              mem_busy, adv, pipe_empty;
    logic [TCNT_W-1:0] tcnt;
    logic              err_q;

    assign mem_busy   = occ_e & dmem_waitrequest;
    assign pipe_empty = ~(occ_f | occ_r | occ_e | occ_w);

    always_ff @(posedge clk) begin
        if (reset) state <= ST_START;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_START:    state_next = ST_RUN;
            ST_RUN: begin
                if (mem_busy)      state_next = ST_MEM_WAIT;
                else if (halt_req) state_next = ST_DRAIN;
            end
            ST_MEM_WAIT: if (!dmem_waitrequest) state_next = ST_RUN;
            ST_DRAIN:    if (pipe_empty) state_next = ST_HALTED;
            ST_HALTED:   if (!halt_req) state_next = ST_START;
            default:     state_next = ST_START;
        endcase
    end

    always_comb begin
        adv         = ((state == ST_RUN) || (state == ST_DRAIN)) && !mem_busy;
        halted      = (state == ST_HALTED);
        pc_write_en = adv && ((state == ST_RUN) || set_invalid_sig_to_fetch);
        valid_in_fetch_stage     = occ_f & adv;
        valid_in_rf_read_stage   = occ_r & adv;
        valid_in_execute_stage   = occ_e & adv;
        valid_in_writeback_stage = occ_w;
    end

    // Flushes only act on an advancing cycle; a stalled pipe keeps its contents and bubbles W.
    always_ff @(posedge clk) begin
        if (reset) begin
            occ_f <= 1'b0;
            occ_r <= 1'b0;
            occ_e <= 1'b0;
            occ_w <= 1'b0;
        end else if (adv) begin
            occ_f <= (state == ST_RUN) && !halt_req;
            occ_r <= occ_f & ~set_invalid_sig_to_fetch;
            occ_e <= occ_r & ~set_invalid_sig_to_rf_read;
            occ_w <= occ_e;
        end else begin
            occ_w <= 1'b0;
            if (state == ST_START) occ_f <= 1'b1;
        end
    end

    // tcnt saturates at the threshold so the error stays armed for arbitrarily long waits.
    always_ff @(posedge clk) begin
        if (reset) begin
            tcnt  <= '0;
            err_q <= 1'b0;
        end else if (state == ST_MEM_WAIT) begin
            if (!dmem_waitrequest) begin
                tcnt <= '0;
            end else if (tcnt == TCNT_LAST) begin
                err_q <= 1'b1;
            end else begin
                tcnt <= tcnt + 1'b1;
            end
        end
    end

    assign mem_timeout_err = err_q;

`ifdef PIPE_PERF_COUNTERS_EN
    logic [CNT_W-1:0] retired_q, flush_q, stall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            retired_q <= '0;
            flush_q   <= '0;
            stall_q   <= '0;
        end else begin
            if (occ_w && !(&retired_q)) retired_q <= retired_q + 1'b1;
            if (adv && set_invalid_sig_to_fetch && !(&flush_q)) flush_q <= flush_q + 1'b1;
            if ((state == ST_MEM_WAIT) && !(&stall_q)) stall_q <= stall_q + 1'b1;
        end
    end

    assign perf_retired = retired_q;
    assign perf_flush   = flush_q;
    assign perf_stall   = stall_q;
`else
    assign perf_retired = '0;
    assign perf_flush   = '0;
    assign perf_stall   = '0;
`endif

endmodule

// File: tb/tb_pipe_valid_controller.sv
// tb/tb_pipe_valid_controller.sv - randomized scoreboard bench for pipe_valid_controller
module tb_pipe_valid_controller;

    localparam int TO     = 8;
    localparam int CW     = 8;
    localparam int CMAX   = (1 << CW) - 1;
    localparam int NCYC   = 4000;

    localparam int M_BOOT  = 0;
    localparam int M_GO    = 1;
    localparam int M_STALL = 2;
    localparam int M_EMPTY = 3;
    localparam int M_PARK  = 4;

    logic clk = 1'b0;
    logic reset, kf, kr, wr, hr;
    logic vf, vr, ve, vw, pcw, hlt, err;
    logic [CW-1:0] p_ret, p_fl, p_st;

    pipe_valid_controller #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk                        (clk),
        .reset                      (reset),
        .set_invalid_sig_to_fetch   (kf),
        .set_invalid_sig_to_rf_read (kr),
        .dmem_waitrequest           (wr),
        .halt_req                   (hr),
        .valid_in_fetch_stage       (vf),
        .valid_in_rf_read_stage     (vr),
        .valid_in_execute_stage     (ve),
        .valid_in_writeback_stage   (vw),
        .pc_write_en                (pcw),
        .halted                     (hlt),
        .mem_timeout_err            (err),
        .perf_retired               (p_ret),
        .perf_flush                 (p_fl),
        .perf_stall                 (p_st)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic vf, vr, ve, vw, pcw, hlt, err;
        logic [CW-1:0] ret, fl, st;
    } exp_t;

    exp_t sb_q[$];
    int checks = 0;
    int passed = 0;

    // Reference model: instruction tags travelling through four slots (0 = empty).
    int slot[4];
    int mode, next_id, stall_cycles, c_ret, c_fl, c_st;
    bit err_m;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) slot[i] = 0;
        mode = M_BOOT;
        stall_cycles = 0;
        err_m = 1'b0;
        c_ret = 0;
        c_fl = 0;
        c_st = 0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk("valid_in_fetch_stage",     32'(vf),    32'(e.vf));
            chk("valid_in_rf_read_stage",   32'(vr),    32'(e.vr));
            chk("valid_in_execute_stage",   32'(ve),    32'(e.ve));
            chk("valid_in_writeback_stage", 32'(vw),    32'(e.vw));
            chk("pc_write_en",              32'(pcw),   32'(e.pcw));
            chk("halted",                   32'(hlt),   32'(e.hlt));
            chk("mem_timeout_err",          32'(err),   32'(e.err));
            chk("perf_retired",             32'(p_ret), 32'(e.ret));
            chk("perf_flush",               32'(p_fl),  32'(e.fl));
            chk("perf_stall",               32'(p_st),  32'(e.st));
        end
    end

    initial begin
        reset = 1'b1; kf = 1'b0; kr = 1'b0; wr = 1'b0; hr = 1'b0;
        next_id = 1;
        model_reset();
        @(posedge clk);
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            exp_t e;
            bit busy, go, empty;
            int ns[4];
            #1;
            if (cyc < 3) begin
                reset = 1'b1;
            end else if (cyc < 12) begin
                reset = 1'b0; kf = 1'b0; kr = 1'b0; wr = 1'b0; hr = 1'b0;
            end else begin
                reset = ($urandom_range(0, 299) == 0);
                kf = ($urandom_range(0, 99) < 12);
                kr = ($urandom_range(0, 99) < 8);
                if (wr) begin
                    if ($urandom_range(0, 9) == 0) wr = 1'b0;
                end else begin
                    if ($urandom_range(0, 5) == 0) wr = 1'b1;
                end
                if ($urandom_range(0, 39) == 0) hr = ~hr;
            end

            busy = (slot[2] != 0) && wr;
            go   = ((mode == M_GO) || (mode == M_EMPTY)) && !busy;
            e.vf  = (slot[0] != 0) && go;
            e.vr  = (slot[1] != 0) && go;
            e.ve  = (slot[2] != 0) && go;
            e.vw  = (slot[3] != 0);
            e.pcw = go && ((mode == M_GO) || kf);
            e.hlt = (mode == M_PARK);
            e.err = err_m;
`ifdef PIPE_PERF_COUNTERS_EN
            e.ret = c_ret[CW-1:0];
            e.fl  = c_fl[CW-1:0];
            e.st  = c_st[CW-1:0];
`else
            e.ret = '0;
            e.fl  = '0;
            e.st  = '0;
`endif
            sb_q.push_back(e);

            if (reset) begin
                model_reset();
            end else begin
                if ((slot[3] != 0) && (c_ret < CMAX)) c_ret++;
                if (go && kf && (c_fl < CMAX)) c_fl++;
                if ((mode == M_STALL) && (c_st < CMAX)) c_st++;
                empty = (slot[0] == 0) && (slot[1] == 0) && (slot[2] == 0) && (slot[3] == 0);
                if (go) begin
                    ns[3] = slot[2];
                    ns[2] = kr ? 0 : slot[1];
                    ns[1] = kf ? 0 : slot[0];
                    ns[0] = 0;
                    if ((mode == M_GO) && !hr) ns[0] = next_id++;
                end else begin
                    for (int i = 0; i < 3; i++) ns[i] = slot[i];
                    ns[3] = 0;
                    if (mode == M_BOOT) ns[0] = next_id++;
                end
                case (mode)
                    M_BOOT: mode = M_GO;
                    M_GO: begin
                        if (busy) begin
                            mode = M_STALL;
                            stall_cycles = 0;
                        end else if (hr) begin
                            mode = M_EMPTY;
                        end
                    end
                    M_STALL: begin
                        stall_cycles++;
                        if (!wr) begin
                            mode = M_GO;
                            stall_cycles = 0;
                        end else if (stall_cycles >= TO) begin
                            err_m = 1'b1;
                        end
                    end
                    M_EMPTY: if (empty) mode = M_PARK;
                    default: if (!hr) mode = M_BOOT;
                endcase
                for (int i = 0; i < 4; i++) slot[i] = ns[i];
            end
            @(posedge clk);
        end
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
